csr_trap_ctrl: RTL and testbench

- Sequences machine-mode trap entry (exceptions, interrupts) and MRET return for the CSR register file.
- Owns the CSR file's single write port. It arbitrates that port between pipeline CSR-instruction writes and its own multi-cycle trap/return write sequences.
- Drives pipeline flush and redirect. Tracks the current privilege mode.
- Sits between the commit stage and the CSR register file.

---
 rtl/csr_trap_ctrl_if.sv | 23 ++
 rtl/csr_trap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_if.sv
// CSR write-port bundle: pipeline write request handshake plus the CSR file write port.
// master = pipeline/CSR-file side, slave = csr_trap_ctrl.
interface csr_trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            csr_req_valid;
  logic [11:0]     csr_req_addr;
  logic [XLEN-1:0] csr_req_wdata;
  logic            csr_req_ready;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;

  modport master (
    output csr_req_valid, csr_req_addr, csr_req_wdata,
    input  csr_req_ready, csr_we, csr_waddr, csr_wdata
  );

  modport slave (
    input  csr_req_valid, csr_req_addr, csr_req_wdata,
    output csr_req_ready, csr_we, csr_waddr, csr_wdata
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer owning the CSR file write port.
// Optional macro CSR_TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 1).
module csr_trap_ctrl #(
  parameter int XLEN        = 64,
  parameter int MTVAL_WRITE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exc_valid,
  input  logic [XLEN-1:0]  exc_cause,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic [XLEN-1:0]  exc_tval,
  input  logic             mret_valid,
  input  logic [XLEN-1:0]  irq_pc,
  input  logic [XLEN-1:0]  mip_in,
  input  logic [XLEN-1:0]  mie_in,
  input  logic [XLEN-1:0]  mstatus_in,
  input  logic [XLEN-1:0]  mtvec_in,
  input  logic [XLEN-1:0]  mepc_in,
  csr_trap_ctrl_if.slave   bus,
  output logic             flush,
  output logic             stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       priv_mode,
  output logic             busy
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_STATUS, REDIRECT, R_STATUS, R_REDIRECT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            mei, msi, mti, irq_take;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] status_wr;
  logic            unused_irq_bits;

  // Only MEI/MSI/MTI are serviced; the remaining pending bits are deliberately ignored.
  assign unused_irq_bits = ^{mip_in, mie_in};

  always_comb begin
    mei      = mip_in[11] & mie_in[11];
    msi      = mip_in[3]  & mie_in[3];
    mti      = mip_in[7]  & mie_in[7];
    irq_take = ((priv_q != 2'd3) || mstatus_in[MIE_BIT]) && (mei || msi || mti);
    irq_code = mei ? 4'd11 : (msi ? 4'd3 : 4'd7);
  end

  always_comb begin
    trap_tgt = mtvec_in & ~XLEN'(3);
`ifdef CSR_TRAP_VECTORED_EN
    if (cause_q[XLEN-1] && (mtvec_in[1:0] == 2'b01))
      trap_tgt = trap_tgt + {cause_q[XLEN-3:0], 2'b00};
`endif
  end

  always_comb begin
    state_d            = state_q;
    priv_d             = priv_q;
    cause_d            = cause_q;
    pc_d               = pc_q;
    tval_d             = tval_q;
    status_d           = status_q;
    target_d           = target_q;
    bus.csr_req_ready  = 1'b0;
    bus.csr_we         = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    flush              = 1'b0;
    stall              = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    status_wr          = status_q;

    unique case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (exc_valid || irq_take) begin
          cause_d  = exc_valid ? exc_cause : {1'b1, (XLEN-1)'(irq_code)};
          pc_d     = exc_valid ? exc_pc : irq_pc;
          tval_d   = exc_valid ? exc_tval : '0;
          status_d = mstatus_in;
          flush    = 1'b1;
          stall    = 1'b1;
          state_d  = W_MEPC;
        end else if (mret_valid) begin
          status_d = mstatus_in;
          flush    = 1'b1;
          stall    = 1'b1;
          state_d  = R_STATUS;
        end else if (bus.csr_req_valid) begin
          bus.csr_req_ready = 1'b1;
          bus.csr_we        = 1'b1;
          bus.csr_waddr     = bus.csr_req_addr;
          bus.csr_wdata     = bus.csr_req_wdata;
        end
      end
      W_MEPC: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = ADDR_MEPC;
        bus.csr_wdata = pc_q & ~XLEN'(3);
        state_d       = W_MCAUSE;
      end
      W_MCAUSE: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = ADDR_MCAUSE;
        bus.csr_wdata = cause_q;
        state_d       = (MTVAL_WRITE != 0) ? W_MTVAL : W_STATUS;
      end
      W_MTVAL: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = ADDR_MTVAL;
        bus.csr_wdata = tval_q;
        state_d       = W_STATUS;
      end
      W_STATUS: begin
        status_wr[MPIE_BIT] = status_q[MIE_BIT];
        status_wr[MIE_BIT]  = 1'b0;
        status_wr[12:11]    = priv_q;
        bus.csr_we          = 1'b1;
        bus.csr_waddr       = ADDR_MSTATUS;
        bus.csr_wdata       = status_wr;
        priv_d              = 2'd3;
        state_d             = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_tgt;
        state_d        = IDLE;
      end
      R_STATUS: begin
        status_wr[MIE_BIT]  = status_q[MPIE_BIT];
        status_wr[MPIE_BIT] = 1'b1;
        status_wr[12:11]    = 2'd0;
        bus.csr_we          = 1'b1;
        bus.csr_waddr       = ADDR_MSTATUS;
        bus.csr_wdata       = status_wr;
        priv_d              = status_q[12:11];
        target_d            = mepc_in;
        state_d             = R_REDIRECT;
      end
      R_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      priv_q   <= 2'd3;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      status_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      priv_q   <= priv_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      status_q <= status_d;
      target_q <= target_d;
    end
  end

  assign priv_mode = priv_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed test-plan steps followed by randomized events
// checked cycle-by-cycle against a transaction-level model of trap/MRET/CSR-write behaviour.
module tb_csr_trap_ctrl;
  localparam int XLEN        = 64;
  localparam int MTVAL_WRITE = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            exc_valid, mret_valid;
  logic [XLEN-1:0] exc_cause, exc_pc, exc_tval, irq_pc;
  logic [XLEN-1:0] mip_in, mie_in, mstatus_in, mtvec_in, mepc_in;
  logic            flush, stall, redirect_valid, busy;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      priv_mode;

  csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  csr_trap_ctrl #(.XLEN(XLEN), .MTVAL_WRITE(MTVAL_WRITE)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_pc(irq_pc),
    .mip_in(mip_in), .mie_in(mie_in), .mstatus_in(mstatus_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .bus(bus),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .priv_mode(priv_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        flush;
    logic        stall;
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  priv;
    logic        busy;
  } exp_t;

  exp_t         q[$];
  logic [75:0]  wlog[$];
  logic [63:0]  last_rpc;
  int           rv_cyc;
  int           checks = 0;
  int           errors = 0;
  logic [1:0]   mp = 2'd3;   // model privilege mode
  bit           hold_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_valid = 0; mret_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; irq_pc = 0;
    mip_in = 0; mie_in = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
    bus.csr_req_valid = 0; bus.csr_req_addr = 0; bus.csr_req_wdata = 0;
  endtask

  function automatic exp_t mkw(input logic [11:0] a, input logic [63:0] d, input logic [1:0] p);
    exp_t r = '0;
    r.we = 1; r.addr = a; r.data = d; r.stall = 1; r.busy = 1; r.priv = p;
    return r;
  endfunction

  // Expands the event presented this cycle into the full list of expected per-cycle outputs.
  task automatic build();
    logic [63:0] pend, cause, pc, tval, st, tgt;
    int code;
    bit irq;
    exp_t r;
    pend = mip_in & mie_in;
    code = -1;
    if (mp != 2'd3 || mstatus_in[3]) begin
      if (pend[11]) code = 11;
      else if (pend[3]) code = 3;
      else if (pend[7]) code = 7;
    end
    r = '0; r.priv = mp;
    if (exc_valid || code >= 0) begin
      irq   = !exc_valid;
      cause = irq ? {1'b1, 63'(code)} : exc_cause;
      pc    = irq ? irq_pc : exc_pc;
      tval  = irq ? 64'd0 : exc_tval;
      r.flush = 1; r.stall = 1;
      q.push_back(r);
      q.push_back(mkw(12'h341, {pc[63:2], 2'b00}, mp));
      q.push_back(mkw(12'h342, cause, mp));
      if (MTVAL_WRITE != 0) q.push_back(mkw(12'h343, tval, mp));
      st = mstatus_in; st[7] = mstatus_in[3]; st[3] = 1'b0; st[12:11] = mp;
      q.push_back(mkw(12'h300, st, mp));
      tgt = {mtvec_in[63:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
      if (irq && mtvec_in[1:0] == 2'b01) tgt = tgt + 64'(4 * code);
`endif
      mp = 2'd3;
      r = '0; r.rv = 1; r.rpc = tgt; r.stall = 1; r.busy = 1; r.priv = mp;
      q.push_back(r);
    end else if (mret_valid) begin
      r.flush = 1; r.stall = 1;
      q.push_back(r);
      st = mstatus_in; st[3] = mstatus_in[7]; st[7] = 1'b1; st[12:11] = 2'b00;
      q.push_back(mkw(12'h300, st, mp));
      mp = mstatus_in[12:11];
      r = '0; r.rv = 1; r.rpc = mepc_in; r.stall = 1; r.busy = 1; r.priv = mp;
      q.push_back(r);
    end else if (bus.csr_req_valid) begin
      r.ready = 1; r.we = 1; r.addr = bus.csr_req_addr; r.data = bus.csr_req_wdata;
      q.push_back(r);
    end else begin
      q.push_back(r);
    end
  endtask

  task automatic busy_inputs();
    exc_valid  = 1'($urandom);
    mret_valid = 1'($urandom);
    mip_in     = {$urandom, $urandom};
    mie_in     = {$urandom, $urandom};
    if (!hold_req) begin
      bus.csr_req_valid = 1'($urandom);
      bus.csr_req_addr  = 12'($urandom);
      bus.csr_req_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic compare(input exp_t e, input int n);
    chk("csr_req_ready", 64'(bus.csr_req_ready), 64'(e.ready));
    chk("csr_we", 64'(bus.csr_we), 64'(e.we));
    if (e.we) begin
      chk("csr_waddr", 64'(bus.csr_waddr), 64'(e.addr));
      chk("csr_wdata", bus.csr_wdata, e.data);
    end
    chk("flush", 64'(flush), 64'(e.flush));
    chk("stall", 64'(stall), 64'(e.stall));
    chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
    if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
    chk("priv_mode", 64'(priv_mode), 64'(e.priv));
    chk("busy", 64'(busy), 64'(e.busy));
    if (bus.csr_we) wlog.push_back({bus.csr_waddr, bus.csr_wdata});
    if (redirect_valid) begin
      last_rpc = redirect_pc;
      rv_cyc   = n;
    end
  endtask

  // Caller has applied cycle-0 inputs at posedge+1; returns at posedge+1 of the next idle cycle.
  task automatic run_event();
    exp_t e;
    int n = 0;
    build();
    while (q.size() > 0) begin
      e = q.pop_front();
      if (n > 0) busy_inputs();
      #3;
      compare(e, n);
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_priv", 64'(priv_mode), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(bus.csr_we), 64'd0);
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_flush_stall", 64'({flush, stall}), 64'd0);
    reset = 0;
    @(posedge clk); #1;

    // Ecall from M-mode
    clear_inputs(); wlog.delete();
    exc_valid = 1; exc_cause = 64'd11; exc_pc = 64'h8000_0010;
    mstatus_in = 64'h8; mtvec_in = 64'h8000_1000;
    run_event();
    chk("ecall_nwr", 64'(wlog.size()), 64'd4);
    chk("ecall_mepc", 64'(wlog[0]), {12'h341, 64'h8000_0010});
    chk("ecall_mcause", 64'(wlog[1]), {12'h342, 64'd11});
    chk("ecall_mstatus", wlog[3][63:0], 64'h1880);
    chk("ecall_rpc", last_rpc, 64'h8000_1000);
    chk("ecall_lat", 64'(rv_cyc), (MTVAL_WRITE != 0) ? 64'd5 : 64'd4);
    chk("ecall_priv", 64'(priv_mode), 64'd3);

    // MRET to U-mode
    clear_inputs(); wlog.delete();
    mret_valid = 1; mstatus_in = 64'h80; mepc_in = 64'h8000_0014;
    run_event();
    chk("mret_mstatus", 64'(wlog[0]), {12'h300, 64'h88});
    chk("mret_rpc", last_rpc, 64'h8000_0014);
    chk("mret_lat", 64'(rv_cyc), 64'd2);
    chk("mret_priv", 64'(priv_mode), 64'd0);

    // MEI wins over MSI/MTI
    clear_inputs(); wlog.delete();
    mip_in = 64'h888; mie_in = 64'h888; mstatus_in = 64'h8;
    irq_pc = 64'h8000_0020; mtvec_in = 64'h8000_1001;
    run_event();
    chk("irq_mepc", 64'(wlog[0]), {12'h341, 64'h8000_0020});
    chk("irq_mcause", wlog[1][63:0], 64'h8000_0000_0000_000B);
    chk("irq_mtval", 64'(wlog[2]), {12'h343, 64'd0});
`ifdef CSR_TRAP_VECTORED_EN
    chk("irq_rpc", last_rpc, 64'h8000_102C);
`else
    chk("irq_rpc", last_rpc, 64'h8000_1000);
`endif

    // Exception beats a same-cycle CSR write; the write lands right after the redirect
    clear_inputs(); wlog.delete(); hold_req = 1;
    exc_valid = 1; exc_cause = 64'd2; exc_pc = 64'h8000_0103; exc_tval = 64'hDEAD;
    bus.csr_req_valid = 1; bus.csr_req_addr = 12'h340; bus.csr_req_wdata = 64'h1234;
    run_event();
    exc_valid = 0; mret_valid = 0; mip_in = 0; mie_in = 0;
    run_event();
    hold_req = 0;
    chk("pend_nwr", 64'(wlog.size()), (MTVAL_WRITE != 0) ? 64'd5 : 64'd4);
    chk("pend_write", 64'(wlog[wlog.size()-1]), {12'h340, 64'h1234});

    // Pending interrupt masked by MIE=0 in M-mode: CSR write passes straight through
    clear_inputs(); wlog.delete();
    mip_in = 64'h888; mie_in = 64'h888; mstatus_in = 64'h0;
    bus.csr_req_valid = 1; bus.csr_req_addr = 12'h305; bus.csr_req_wdata = 64'hABCD;
    run_event();
    chk("masked_write", 64'(wlog[0]), {12'h305, 64'hABCD});
    chk("masked_busy", 64'(busy), 64'd0);

    // Drop to U-mode, then reset during W_MCAUSE
    clear_inputs();
    mret_valid = 1; mstatus_in = 64'h0;
    run_event();
    clear_inputs();
    exc_valid = 1; exc_cause = 64'd8; exc_pc = 64'h100;
    #3; @(posedge clk); #1;
    exc_valid = 0;
    @(posedge clk); #1;
    chk("mid_waddr", 64'(bus.csr_waddr), 64'h342);
    chk("mid_priv", 64'(priv_mode), 64'd0);
    reset = 1; #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_priv", 64'(priv_mode), 64'd3);
    chk("abort_we", 64'(bus.csr_we), 64'd0);
    chk("abort_rv", 64'(redirect_valid), 64'd0);
    @(posedge clk); #1;
    reset = 0; mp = 2'd3;
    @(posedge clk); #1;
    chk("post_abort_busy", 64'(busy), 64'd0);

    // Randomized events against the model
    for (int i = 0; i < 300; i++) begin
      clear_inputs();
      exc_valid         = ($urandom_range(0, 3) == 0);
      mret_valid        = ($urandom_range(0, 3) == 0);
      exc_cause         = 64'($urandom_range(0, 15));
      exc_pc            = {$urandom, $urandom};
      exc_tval          = {$urandom, $urandom};
      irq_pc            = {$urandom, $urandom};
      mip_in            = 64'($urandom) & 64'hFFF;
      mie_in            = 64'($urandom) & 64'hFFF;
      if ($urandom_range(0, 1) == 0) mie_in = 64'h0;
      mstatus_in        = {$urandom, $urandom};
      mtvec_in          = {$urandom, $urandom};
      mepc_in           = {$urandom, $urandom};
      bus.csr_req_valid = 1'($urandom);
      bus.csr_req_addr  = 12'($urandom);
      bus.csr_req_wdata = {$urandom, $urandom};
      run_event();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
